// File: rtl/freq_meter.sv
// freq_meter: measures an asynchronous square wave in two ways.
//   - frequency: rising edges counted per GATE_CYCLES-long gate window
//   - period:    clk cycles between consecutive rising edges
// Optional build macro FREQ_METER_FILTER_EN inserts a 3-sample agreement
// filter after the synchronizer, so input pulses shorter than 3 cycles are
// rejected (edge latency grows from 2 to 4 cycles).
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 32000000,
    parameter int unsigned COUNT_BITS  = 24
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic                  sig_in,
    output logic [COUNT_BITS-1:0] freq_count,
    output logic                  freq_valid,
    output logic                  freq_ovf,
    output logic [COUNT_BITS-1:0] period_count,
    output logic                  period_valid,
    output logic                  period_ovf
);

    localparam int unsigned           GATE_BITS = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_BITS-1:0]  GATE_LAST = GATE_BITS'(GATE_CYCLES - 1);
    localparam logic [COUNT_BITS-1:0] CNT_MAX   = {COUNT_BITS{1'b1}};
    localparam logic [COUNT_BITS-1:0] CNT_ONE   = COUNT_BITS'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic w_level;
    logic w_edge_evt;

    // Two-flop synchronizer; keeps running while disabled so re-enable sees no false edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= sig_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef FREQ_METER_FILTER_EN
    logic [1:0] r_hist;

    // History of the two previous synchronized samples for the agreement check
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hist <= 2'b00;
        end else begin
            r_hist <= {r_hist[0], r_sync2};
        end
    end

    // Level follows the input only once three consecutive samples agree
    assign w_level = ((r_sync2 == r_hist[0]) && (r_sync2 == r_hist[1])) ? r_sync2 : r_prev;
`else
    assign w_level = r_sync2;
`endif

    // Previous conditioned level, used for rising-edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_level;
        end
    end

    assign w_edge_evt = w_level & ~r_prev;

    // ------------------------------------------------------------------
    // Frequency: gate window and saturating edge counter
    // ------------------------------------------------------------------
    logic [GATE_BITS-1:0]  r_gate_cnt;
    logic [COUNT_BITS-1:0] r_edge_cnt;
    logic                  r_edge_sat;
    logic [COUNT_BITS-1:0] r_freq_count;
    logic                  r_freq_valid;
    logic                  r_freq_ovf;
    logic                  w_gate_last;
    logic                  w_edge_full;

    assign w_gate_last = (r_gate_cnt == GATE_LAST);
    assign w_edge_full = (r_edge_cnt == CNT_MAX);

    // Gate counting; the terminal cycle's own edge belongs to the closing window
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_gate_cnt   <= '0;
            r_edge_cnt   <= '0;
            r_edge_sat   <= 1'b0;
            r_freq_count <= '0;
            r_freq_valid <= 1'b0;
            r_freq_ovf   <= 1'b0;
        end else begin
            r_freq_valid <= 1'b0;
            if (!enable) begin
                r_gate_cnt <= '0;
                r_edge_cnt <= '0;
                r_edge_sat <= 1'b0;
            end else if (w_gate_last) begin
                r_gate_cnt   <= '0;
                r_edge_cnt   <= '0;
                r_edge_sat   <= 1'b0;
                r_freq_count <= (w_edge_evt && !w_edge_full) ? (r_edge_cnt + CNT_ONE) : r_edge_cnt;
                r_freq_ovf   <= r_edge_sat | (w_edge_evt & w_edge_full);
                r_freq_valid <= 1'b1;
            end else begin
                r_gate_cnt <= r_gate_cnt + GATE_BITS'(1);
                if (w_edge_evt) begin
                    if (w_edge_full) begin
                        r_edge_sat <= 1'b1;
                    end else begin
                        r_edge_cnt <= r_edge_cnt + CNT_ONE;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Period: IDLE / ARM / MEAS state machine
    // ------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_next;
    logic [COUNT_BITS-1:0] r_per_cnt;
    logic [COUNT_BITS-1:0] w_per_cnt_next;
    logic                  w_per_load;
    logic [COUNT_BITS-1:0] w_per_result;
    logic                  w_per_ovf;
    logic [COUNT_BITS-1:0] r_period_count;
    logic                  r_period_valid;
    logic                  r_period_ovf;

    // State and period counter registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_per_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_per_cnt <= w_per_cnt_next;
        end
    end

    // Next state, counter update and result latch request
    always_comb begin
        w_state_next   = r_state;
        w_per_cnt_next = r_per_cnt;
        w_per_load     = 1'b0;
        w_per_result   = r_per_cnt;
        w_per_ovf      = 1'b0;
        if (!enable) begin
            w_state_next   = ST_IDLE;
            w_per_cnt_next = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next   = ST_ARM;
                    w_per_cnt_next = '0;
                end
                ST_ARM: begin
                    if (w_edge_evt) begin
                        w_state_next   = ST_MEAS;
                        w_per_cnt_next = CNT_ONE;
                    end
                end
                ST_MEAS: begin
                    if (w_edge_evt) begin
                        // an edge wins over a simultaneous saturation
                        w_per_load     = 1'b1;
                        w_per_result   = r_per_cnt;
                        w_per_ovf      = 1'b0;
                        w_per_cnt_next = CNT_ONE;
                    end else if (r_per_cnt == CNT_MAX) begin
                        w_per_load     = 1'b1;
                        w_per_result   = CNT_MAX;
                        w_per_ovf      = 1'b1;
                        w_state_next   = ST_ARM;
                        w_per_cnt_next = '0;
                    end else begin
                        w_per_cnt_next = r_per_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_next   = ST_IDLE;
                    w_per_cnt_next = '0;
                end
            endcase
        end
    end

    // Period result registers and strobe
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_period_count <= '0;
            r_period_valid <= 1'b0;
            r_period_ovf   <= 1'b0;
        end else begin
            r_period_valid <= w_per_load;
            if (w_per_load) begin
                r_period_count <= w_per_result;
                r_period_ovf   <= w_per_ovf;
            end
        end
    end

    assign freq_count   = r_freq_count;
    assign freq_valid   = r_freq_valid;
    assign freq_ovf     = r_freq_ovf;
    assign period_count = r_period_count;
    assign period_valid = r_period_valid;
    assign period_ovf   = r_period_ovf;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: GATE_CYCLES=100 / COUNT_BITS=8 main instance plus a
// GATE_CYCLES=600 instance for frequency saturation.
`timescale 1ns/1ps
module tb_freq_meter;

    localparam int CLK_T = 10;
`ifdef FREQ_METER_FILTER_EN
    localparam int LAT = 4;
    localparam int NV  = 5;
`else
    localparam int LAT = 2;
    localparam int NV  = 7;
`endif

    typedef struct packed {
        logic [7:0] cnt;
        logic       ovf;
    } res_t;

    typedef struct {
        int         hi;
        int         lo;
        logic [7:0] exp_freq;
        logic [7:0] exp_per;
    } vec_t;

    logic       clk  = 1'b0;
    logic       rstn = 1'b1;
    logic       en   = 1'b0;
    logic       sig  = 1'b0;
    logic       en2  = 1'b0;
    logic       sig2 = 1'b0;

    logic [7:0] freq_count, period_count, freq2_count, period2_count;
    logic       freq_valid, freq_ovf, period_valid, period_ovf;
    logic       freq2_valid, freq2_ovf, period2_valid, period2_ovf;

    int         n_tests = 0;
    int         n_fail  = 0;

    res_t       q_freq[$];
    res_t       q_per[$];
    res_t       q_sat[$];
    res_t       e_f, e_p, e_s;
    bit         per_free = 1'b0;
    logic [7:0] per_free_exp = 8'd0;
    int         per_seen = 0;
    time        t_freq_last = 0;
    time        t_per_last  = 0;

    always #(CLK_T/2) clk = ~clk;

    freq_meter #(.GATE_CYCLES(100), .COUNT_BITS(8)) u_dut (
        .clk(clk), .rstn(rstn), .enable(en), .sig_in(sig),
        .freq_count(freq_count), .freq_valid(freq_valid), .freq_ovf(freq_ovf),
        .period_count(period_count), .period_valid(period_valid), .period_ovf(period_ovf)
    );

    freq_meter #(.GATE_CYCLES(600), .COUNT_BITS(8)) u_dut_sat (
        .clk(clk), .rstn(rstn), .enable(en2), .sig_in(sig2),
        .freq_count(freq2_count), .freq_valid(freq2_valid), .freq_ovf(freq2_ovf),
        .period_count(period2_count), .period_valid(period2_valid), .period_ovf(period2_ovf)
    );

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input int unsigned val);
        n_tests++;
        n_fail++;
        $display("FAIL %s: strobe with value %0d, none expected", name, val);
    endtask

    task automatic push_f(input logic [7:0] c, input logic o);
        res_t r;
        r.cnt = c;
        r.ovf = o;
        q_freq.push_back(r);
    endtask

    task automatic push_p(input logic [7:0] c, input logic o);
        res_t r;
        r.cnt = c;
        r.ovf = o;
        q_per.push_back(r);
    endtask

    task automatic push_s(input logic [7:0] c, input logic o);
        res_t r;
        r.cnt = c;
        r.ovf = o;
        q_sat.push_back(r);
    endtask

    // Frequency scoreboard for the main instance
    always @(negedge clk) begin
        if (freq_valid) begin
            t_freq_last = $time;
            if (q_freq.size() == 0) begin
                unexpected("freq_unexpected", 32'(freq_count));
            end else begin
                e_f = q_freq.pop_front();
                check("freq_count", 32'(freq_count), 32'(e_f.cnt));
                check("freq_ovf", 32'(freq_ovf), 32'(e_f.ovf));
            end
        end
    end

    // Period scoreboard: either a fixed expected value or queued results
    always @(negedge clk) begin
        if (period_valid) begin
            t_per_last = $time;
            per_seen++;
            if (per_free) begin
                check("period_count", 32'(period_count), 32'(per_free_exp));
                check("period_ovf", 32'(period_ovf), 32'(0));
            end else if (q_per.size() == 0) begin
                unexpected("period_unexpected", 32'(period_count));
            end else begin
                e_p = q_per.pop_front();
                check("period_count_q", 32'(period_count), 32'(e_p.cnt));
                check("period_ovf_q", 32'(period_ovf), 32'(e_p.ovf));
            end
        end
    end

    // Frequency scoreboard for the saturation instance
    always @(negedge clk) begin
        if (freq2_valid) begin
            if (q_sat.size() == 0) begin
                unexpected("sat_unexpected", 32'(freq2_count));
            end else begin
                e_s = q_sat.pop_front();
                check("sat_count", 32'(freq2_count), 32'(e_s.cnt));
                check("sat_ovf", 32'(freq2_ovf), 32'(e_s.ovf));
            end
        end
    end

    initial begin
        #(1_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[NV];
        int   p, ph, j;
        time  t0, t_re;

`ifdef FREQ_METER_FILTER_EN
        vecs[0] = '{5, 5, 8'd10, 8'd10};
        vecs[1] = '{10, 10, 8'd5, 8'd20};
        vecs[2] = '{13, 12, 8'd4, 8'd25};
        vecs[3] = '{50, 50, 8'd1, 8'd100};
        vecs[4] = '{3, 7, 8'd10, 8'd10};
`else
        vecs[0] = '{5, 5, 8'd10, 8'd10};
        vecs[1] = '{10, 10, 8'd5, 8'd20};
        vecs[2] = '{2, 3, 8'd20, 8'd5};
        vecs[3] = '{1, 1, 8'd50, 8'd2};
        vecs[4] = '{3, 1, 8'd25, 8'd4};
        vecs[5] = '{13, 12, 8'd4, 8'd25};
        vecs[6] = '{50, 50, 8'd1, 8'd100};
`endif

        // Reset with the input toggling, then idle with enable low
        #2 rstn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sig = ~sig;
            if (i == 4 || i == 9)
                check("reset_outs", 32'({freq_count, freq_valid, freq_ovf,
                                         period_count, period_valid, period_ovf}), 32'(0));
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if ((i % 4) == 0) sig = ~sig;
        end
        check("idle_outs", 32'({freq_count, freq_valid, freq_ovf,
                                period_count, period_valid, period_ovf}), 32'(0));

        // Steady periodic input: three windows per table entry
        for (int v = 0; v < NV; v++) begin
            p            = vecs[v].hi + vecs[v].lo;
            ph           = 0;
            per_free_exp = vecs[v].exp_per;
            per_seen     = 0;
            per_free     = 1'b1;
            for (int w = 0; w < 3; w++) push_f(vecs[v].exp_freq, 1'b0);
            for (int k = 0; k < 352; k++) begin
                @(negedge clk);
                sig = (ph < vecs[v].hi);
                ph  = (ph + 1 == p) ? 0 : ph + 1;
                en  = (k >= 20 && k < 322);
            end
            per_free = 1'b0;
            check("steady_pending", 32'(q_freq.size()), 32'(0));
            check("steady_per_seen", 32'(per_seen >= (301 / p - 1)), 32'(1));
            check("hold_freq", 32'(freq_count), 32'(vecs[v].exp_freq));
        end

        // Boundary: edge on gate cycle 99 closes window 1; on cycle 100 opens window 2
        for (int b = 0; b < 2; b++) begin
            sig = 1'b0;
            en  = 1'b0;
            repeat (10) @(negedge clk);
            if (b == 0) begin
                push_f(8'd1, 1'b0);
                push_f(8'd0, 1'b0);
            end else begin
                push_f(8'd0, 1'b0);
                push_f(8'd1, 1'b0);
            end
            j = 99 + b - LAT;
            for (int k = 0; k < 212; k++) begin
                @(negedge clk);
                en  = (k < 205);
                sig = (k >= j && k < j + 8);
            end
            check("boundary_pending", 32'(q_freq.size()), 32'(0));
        end

        // Period timeout after a single edge, then a re-arming edge with no strobe
        sig = 1'b0;
        en  = 1'b0;
        repeat (10) @(negedge clk);
        push_f(8'd1, 1'b0);
        push_f(8'd0, 1'b0);
        push_f(8'd0, 1'b0);
        push_f(8'd1, 1'b0);
        push_f(8'd0, 1'b0);
        push_p(8'd255, 1'b1);
        t0 = 0;
        for (int k = 0; k < 520; k++) begin
            @(negedge clk);
            if (k == 0) t0 = $time;
            en  = (k < 500);
            sig = (k >= 10 && k < 280) || (k >= 300);
        end
        check("timeout_freq_pending", 32'(q_freq.size()), 32'(0));
        check("timeout_per_pending", 32'(q_per.size()), 32'(0));
        check("timeout_delay", 32'((t_per_last - t0) / CLK_T), 32'(10 + LAT + 256));

        // Glitch pulses of two cycles
        sig = 1'b0;
        en  = 1'b0;
        repeat (10) @(negedge clk);
`ifdef FREQ_METER_FILTER_EN
        push_f(8'd0, 1'b0);
`else
        push_f(8'd3, 1'b0);
        push_p(8'd10, 1'b0);
        push_p(8'd10, 1'b0);
`endif
        for (int k = 0; k < 112; k++) begin
            @(negedge clk);
            en  = (k < 105);
            sig = (k == 10 || k == 11 || k == 20 || k == 21 || k == 30 || k == 31);
        end
        check("glitch_freq_pending", 32'(q_freq.size()), 32'(0));
        check("glitch_per_pending", 32'(q_per.size()), 32'(0));

`ifndef FREQ_METER_FILTER_EN
        // Frequency saturation on the 600-cycle gate, then recovery at period 10
        push_s(8'd255, 1'b1);
        push_s(8'd60, 1'b0);
        for (int k = 0; k < 1250; k++) begin
            @(negedge clk);
            j    = k - 20;
            en2  = (j >= 0 && j < 1210);
            sig2 = (j < 598) ? ((k % 2) == 0) : (((j - 598) % 10) < 5);
        end
        check("sat_pending", 32'(q_sat.size()), 32'(0));
        check("sat_hold", 32'({freq2_count, freq2_ovf}), 32'({8'd60, 1'b0}));
`endif

        // Enable dropout mid-window; next strobe 100 cycles after re-enable
        per_free_exp = 8'd10;
        per_free     = 1'b1;
        push_f(8'd10, 1'b0);
        ph   = 0;
        t_re = 0;
        for (int k = 0; k < 220; k++) begin
            @(negedge clk);
            sig = (ph < 5);
            ph  = (ph + 1 == 10) ? 0 : ph + 1;
            en  = (k >= 20 && k < 70) || (k >= 100 && k < 210);
            if (k == 100) t_re = $time;
        end
        check("dropout_pending", 32'(q_freq.size()), 32'(0));
        check("reenable_delay", 32'((t_freq_last - t_re) / CLK_T), 32'(100));

        // Reset asserted mid-measurement forces all outputs to zero at once
        push_f(8'd10, 1'b0);
        for (int k = 0; k < 170; k++) begin
            @(negedge clk);
            sig = (ph < 5);
            ph  = (ph + 1 == 10) ? 0 : ph + 1;
            en  = (k >= 20);
        end
        check("premid_freq", 32'(freq_count), 32'(10));
        rstn = 1'b0;
        #1;
        check("reset_mid", 32'({freq_count, freq_valid, freq_ovf,
                                period_count, period_valid, period_ovf}), 32'(0));
        per_free = 1'b0;
        repeat (5) @(negedge clk);
        en   = 1'b0;
        rstn = 1'b1;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            sig = (ph < 5);
            ph  = (ph + 1 == 10) ? 0 : ph + 1;
        end
        check("post_reset_outs", 32'({freq_count, freq_valid, freq_ovf,
                                     period_count, period_valid, period_ovf}), 32'(0));
        check("final_pending", 32'(q_freq.size() + q_per.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
